// File: rtl/inst_queue_pkg.sv
// Shared constants and entry type for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int IQ_DEPTH_LOG   = 4;
  localparam int IQ_FULL_MARGIN = 2;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [INST_WIDTH-1:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetcher-side and decoder/dispatcher-side signals of the instruction queue.
interface inst_queue_if;
  import inst_queue_pkg::*;

  logic                  valid_if_in;
  logic [INST_WIDTH-1:0] inst_if_in;
  logic [INST_WIDTH-1:0] pc_if_in;
  logic                  full_if_out;
  logic                  rdy_dec_out;
  logic [INST_WIDTH-1:0] inst_dec_out;
  logic [INST_WIDTH-1:0] pc_dec_out;
  logic                  stall_dp_in;

  modport slave (
    input  valid_if_in, inst_if_in, pc_if_in, stall_dp_in,
    output full_if_out, rdy_dec_out, inst_dec_out, pc_dec_out
  );

  modport master (
    output valid_if_in, inst_if_in, pc_if_in, stall_dp_in,
    input  full_if_out, rdy_dec_out, inst_dec_out, pc_dec_out
  );

endinterface

// File: rtl/inst_queue.sv
// Circular show-ahead instruction FIFO between fetcher and decoder,
// flushed on mispredict via clear_in.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH_LOG   = IQ_DEPTH_LOG,
  parameter int FULL_MARGIN = IQ_FULL_MARGIN
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear_in,
  inst_queue_if.slave  iq
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] CNT_HIGH = (DEPTH_LOG+1)'(DEPTH - FULL_MARGIN);

  iq_entry_t            mem [DEPTH];
  iq_entry_t            head_entry;
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG:0]   count;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // A full queue refuses the fetch even when a pop frees a slot this cycle.
  always_comb begin
    empty = (count == '0);
    push  = rdy_in & iq.valid_if_in & (count != CNT_FULL);
    pop   = rdy_in & ~empty & ~iq.stall_dp_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !clear_in) begin
      mem[tail] <= '{inst: iq.inst_if_in, pc: iq.pc_if_in};
    end
  end

  // Empty queue drives zeros so stale storage never reaches the decoder.
  always_comb begin
    head_entry      = mem[head];
    iq.rdy_dec_out  = rdy_in & ~empty;
    iq.inst_dec_out = empty ? '0 : head_entry.inst;
    iq.pc_dec_out   = empty ? '0 : head_entry.pc;
    iq.full_if_out  = (count >= CNT_HIGH);
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed corner cases followed by random traffic.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;

  inst_queue_if iq();

  inst_queue #(.DEPTH_LOG(4), .FULL_MARGIN(MARGIN)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .iq       (iq)
  );

  always #5 clk_in = ~clk_in;

  int        total = 0;
  int        bad   = 0;
  int        m_cnt = 0;
  iq_entry_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; reference model advances right after the edge.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [31:0] i, input logic [31:0] p, input logic s);
    bit pu;
    bit po;
    @(negedge clk_in);
    #1;
    rdy_in = r; clear_in = c;
    iq.valid_if_in = v; iq.inst_if_in = i; iq.pc_if_in = p; iq.stall_dp_in = s;
    @(posedge clk_in);
    #1;
    if (rst_in && r) begin
      if (c) begin
        sb.delete();
        m_cnt = 0;
      end else begin
        pu = v && (m_cnt != DEPTH);
        po = (m_cnt != 0) && !s;
        if (v && !pu) $display("note: fetch of pc %h dropped, queue full", p);
        if (pu) sb.push_back('{inst: i, pc: p});
        m_cnt = m_cnt + int'(pu) - int'(po);
      end
    end
  endtask

  // Monitor: checks the presented head against the scoreboard, retires on pop.
  initial begin
    forever begin
      @(negedge clk_in);
      #3;
      chk("rdy_dec", {31'd0, iq.rdy_dec_out}, {31'd0, rdy_in && (m_cnt != 0)});
      chk("full_if", {31'd0, iq.full_if_out}, {31'd0, m_cnt >= DEPTH - MARGIN});
      if (m_cnt == 0) begin
        chk("inst_empty", iq.inst_dec_out, 32'd0);
        chk("pc_empty", iq.pc_dec_out, 32'd0);
      end else if (sb.size() == 0) begin
        chk("sb_depth", 32'(sb.size()), 32'(m_cnt));
      end else begin
        chk("head_inst", iq.inst_dec_out, sb[0].inst);
        chk("head_pc", iq.pc_dec_out, sb[0].pc);
        if (rst_in && rdy_in && !clear_in && !iq.stall_dp_in) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    iq.valid_if_in = 1'b0; iq.inst_if_in = '0; iq.pc_if_in = '0; iq.stall_dp_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_rdy", {31'd0, iq.rdy_dec_out}, 32'd0);
    chk("rst_full", {31'd0, iq.full_if_out}, 32'd0);
    rst_in = 1'b1;

    // first push visible after one edge
    step(1, 0, 1, 32'h00500093, 32'h0, 1);
    chk("t1_rdy", {31'd0, iq.rdy_dec_out}, 32'd1);
    chk("t1_inst", iq.inst_dec_out, 32'h00500093);
    chk("t1_pc", iq.pc_dec_out, 32'h0);
    step(1, 1, 0, 0, 0, 1);

    // fill to full, then one dropped push
    for (int k = 0; k < 14; k++) begin
      step(1, 0, 1, 32'h1000_0000 + k, 32'h100 + 4*k, 1);
      if (k == 12) chk("t2_not_full_13", {31'd0, iq.full_if_out}, 32'd0);
    end
    chk("t2_full_14", {31'd0, iq.full_if_out}, 32'd1);
    step(1, 0, 1, 32'h1000_000e, 32'h138, 1);
    step(1, 0, 1, 32'h1000_000f, 32'h13c, 1);
    step(1, 0, 1, 32'hdead_beef, 32'h140, 1);
    chk("t2_head_kept", iq.inst_dec_out, 32'h1000_0000);

    // pop with push at full: push lost, then refill wraps tail
    step(1, 0, 1, 32'hbad0_0001, 32'h144, 0);
    step(1, 0, 1, 32'h2000_0000, 32'h200, 1);
    chk("t3_head", iq.inst_dec_out, 32'h1000_0001);
    step(1, 1, 0, 0, 0, 1);

    // stall holds head, release drains in order
    for (int k = 0; k < 5; k++) step(1, 0, 1, 32'h3000_0000 + k, 32'h300 + 4*k, 1);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    chk("t4_head_stalled", iq.inst_dec_out, 32'h3000_0000);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    chk("t4_drained", {31'd0, iq.rdy_dec_out}, 32'd0);

    // global enable low suppresses clear and hides head
    step(1, 0, 1, 32'h3500_0000, 32'h350, 1);
    step(0, 1, 1, 32'h3500_0001, 32'h354, 0);
    chk("rdy_low_out", {31'd0, iq.rdy_dec_out}, 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("rdy_low_kept", iq.inst_dec_out, 32'h3500_0000);

    // clear beats a same-cycle push
    for (int k = 0; k < 5; k++) step(1, 0, 1, 32'h4000_0000 + k, 32'h400 + 4*k, 1);
    step(1, 1, 1, 32'h4000_00ff, 32'h4fc, 0);
    chk("t5_rdy", {31'd0, iq.rdy_dec_out}, 32'd0);
    chk("t5_inst", iq.inst_dec_out, 32'd0);

    // async reset mid-stream
    for (int k = 0; k < 8; k++) step(1, 0, 1, 32'h5000_0000 + k, 32'h500 + 4*k, 1);
    @(negedge clk_in);
    #1;
    iq.valid_if_in = 1'b0;
    rst_in = 1'b0;
    sb.delete();
    m_cnt = 0;
    #1;
    chk("t6_rst_rdy", {31'd0, iq.rdy_dec_out}, 32'd0);
    chk("t6_rst_inst", iq.inst_dec_out, 32'd0);
    chk("t6_rst_pc", iq.pc_dec_out, 32'd0);
    chk("t6_rst_full", {31'd0, iq.full_if_out}, 32'd0);
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    step(1, 0, 1, 32'h6000_0000, 32'habc0, 1);
    chk("t6_pc_after", iq.pc_dec_out, 32'habc0);

    // random traffic; fetcher mostly honours full
    for (int n = 0; n < 3000; n++) begin
      logic r, c, v, s;
      r = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 2) != 0) && ((m_cnt < DEPTH - MARGIN) || ($urandom_range(0, 7) == 0));
      s = ($urandom_range(0, 2) == 0);
      step(r, c, v, $urandom, $urandom, s);
    end
    repeat (20) step(1, 0, 0, 0, 0, 0);
    chk("final_empty", 32'(m_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
